memory_responder: RTL and testbench

Memory-side responder for the SMP control unit's memory strobes. It holds the address register (AR) and a synchronous 8-bit memory array, and it answers `ARload`/`ARinc`, `MEMbus`, `BUSmem` and `we` with pipelined read data and committed writes. A sticky protocol checker flags illegal strobe combinations.

---
 rtl/memory_responder.sv | 127 ++++++++++++
 tb/tb_memory_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
//   Memory-side responder for the SMP control unit's memory strobes. Holds the
//   address register (AR) and a synchronous DATA_W-bit memory array. It serves
//   ARload/ARinc address updates, MEMbus reads and BUSmem/we writes. Read data
//   is registered against the *next* AR value, so a new address is readable
//   one edge after it is loaded. A sticky checker flags illegal strobe
//   combinations.
//
//   Optional feature macro: MEM_WPROT_EN. When it is defined, writes to
//   AR < 16'h0010 are dropped and flagged in err[2]. When it is undefined,
//   every address is writable and err[2] is tied to 0.
//
// Parameters
//   ADDR_W     : AR width and bus address width
//   DATA_W     : memory word width; also the bus low byte used as write data
//   DEPTH_LOG2 : memory has 2^DEPTH_LOG2 words, indexed by AR[DEPTH_LOG2-1:0]
//
// Ports
//   clock     in   single clock, rising edge
//   reset     in   synchronous, active-low reset
//   bus_in    in   CPU internal bus (address for ARload, write data on low bits)
//   ARload    in   load AR from bus_in (has priority over ARinc)
//   ARinc     in   increment AR (wraps)
//   MEMbus    in   memory drives read data toward the CPU
//   BUSmem    in   bus-to-memory write path enable
//   we        in   write enable, effective only together with BUSmem
//   err_clr   in   clear the sticky error flags
//   mem_data  out  registered read data at the current AR
//   mem_drive out  read-data output enable (MEMbus & ~BUSmem)
//   ar_out    out  current AR value
//   err       out  sticky flags: [0] contention, [1] AR conflict,
//                  [2] write-protect violation
module memory_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              ARload,
  input  logic              ARinc,
  input  logic              MEMbus,
  input  logic              BUSmem,
  input  logic              we,
  input  logic              err_clr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_drive,
  output logic [ADDR_W-1:0] ar_out,
  output logic [2:0]        err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]     ar;
  logic [ADDR_W-1:0]     ar_next;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_W-1:0]     wr_data;
  logic                  contention;
  logic                  ar_conflict;
  logic                  wr_attempt;
  logic                  wr_prot;
  logic                  wr_en;
  logic [2:0]            err_set;

  // Address register next value: load beats increment; increment wraps.
  always_comb begin
    ar_next = ar;
    if (ARload) begin
      ar_next = bus_in;
    end else if (ARinc) begin
      ar_next = ar + ADDR_W'(1);
    end
  end

  // Strobe decode. The write address is the AR before any same-cycle update.
  always_comb begin
    contention  = MEMbus & BUSmem;
    ar_conflict = ARload & ARinc;
    wr_attempt  = we & BUSmem & ~MEMbus;
    wr_idx      = ar[DEPTH_LOG2-1:0];
    rd_idx      = ar_next[DEPTH_LOG2-1:0];
    wr_data     = bus_in[DATA_W-1:0];
`ifdef MEM_WPROT_EN
    // Protection compares the full AR, so aliases of the low words above
    // 16'h0010 remain writable.
    wr_prot     = wr_attempt & (ar < ADDR_W'(16'h0010));
`else
    wr_prot     = 1'b0;
`endif
    wr_en       = wr_attempt & ~wr_prot;
    err_set     = {wr_prot, ar_conflict, contention};
  end

  assign mem_drive = MEMbus & ~BUSmem;
  assign ar_out    = ar;

  // Memory array: no reset of contents, but a write in a reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // AR, read pipeline and sticky errors.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ar       <= '0;
      mem_data <= '0;
      err      <= '0;
    end else begin
      ar <= ar_next;
      // Read the word at the next AR; forward a same-cycle write to that word
      // so mem_data always mirrors the array contents at the current AR.
      if (wr_en && (wr_idx == rd_idx)) begin
        mem_data <= wr_data;
      end else begin
        mem_data <= mem[rd_idx];
      end
      // A new error beats a simultaneous clear.
      err <= (err & ~{3{err_clr}}) | err_set;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder
//   Directed self-checking bench for memory_responder with hand-computed
//   expected values. Inputs change 1 time unit after the rising edge; outputs
//   are sampled at that point or just before the next edge.
module tb_memory_responder;

  logic        clock;
  logic        reset;
  logic [15:0] bus_in;
  logic        ARload;
  logic        ARinc;
  logic        MEMbus;
  logic        BUSmem;
  logic        we;
  logic        err_clr;
  logic [7:0]  mem_data;
  logic        mem_drive;
  logic [15:0] ar_out;
  logic [2:0]  err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  memory_responder #(
    .ADDR_W    (16),
    .DATA_W    (8),
    .DEPTH_LOG2(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus_in   (bus_in),
    .ARload   (ARload),
    .ARinc    (ARinc),
    .MEMbus   (MEMbus),
    .BUSmem   (BUSmem),
    .we       (we),
    .err_clr  (err_clr),
    .mem_data (mem_data),
    .mem_drive(mem_drive),
    .ar_out   (ar_out),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_in  = '0;
    ARload  = 1'b0;
    ARinc   = 1'b0;
    MEMbus  = 1'b0;
    BUSmem  = 1'b0;
    we      = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic load(input logic [15:0] a);
    idle();
    ARload = 1'b1;
    bus_in = a;
    tick();
    idle();
  endtask

  task automatic inc();
    idle();
    ARinc = 1'b1;
    tick();
    idle();
  endtask

  task automatic write(input logic [7:0] d);
    idle();
    we     = 1'b1;
    BUSmem = 1'b1;
    bus_in = {8'h00, d};
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();
    check("rst_ar", ar_out, 16'h0000);
    check("rst_data", mem_data, 8'h00);
    check("rst_err", err, 3'b000);
    MEMbus = 1'b1;
    #1 check("drive_memb", mem_drive, 1'b1);
    BUSmem = 1'b1;
    #1 check("drive_both", mem_drive, 1'b0);
    idle();
    reset = 1'b1;
    tick();

    // Load/read latency and write bypass.
    load(16'h0020);
    write(8'h3C);
    check("bypass_20", mem_data, 8'h3C);
    load(16'h0021);
    write(8'hE1);
    check("bypass_21", mem_data, 8'hE1);
    load(16'h0020);
    check("load_rd_20", mem_data, 8'h3C);
    check("load_ar_20", ar_out, 16'h0020);
    MEMbus = 1'b1;
    #1 check("fetch_drive", mem_drive, 1'b1);
    tick();
    check("fetch_data", mem_data, 8'h3C);
    idle();

    // Streaming consecutive words.
    load(16'h0030);
    write(8'hA5);
    check("bypass_30", mem_data, 8'hA5);
    inc();
    write(8'h5A);
    inc();
    write(8'hC3);
    load(16'h0030);
    check("stream_30", mem_data, 8'hA5);
    inc();
    check("stream_31", mem_data, 8'h5A);
    check("stream_ar31", ar_out, 16'h0031);
    inc();
    check("stream_32", mem_data, 8'hC3);
    check("stream_ar32", ar_out, 16'h0032);

    // Write uses pre-increment AR; no bypass to the new address.
    load(16'h0031);
    we = 1'b1; BUSmem = 1'b1; ARinc = 1'b1; bus_in = 16'h0077;
    tick();
    idle();
    check("wrinc_ar", ar_out, 16'h0032);
    check("wrinc_data", mem_data, 8'hC3);
    load(16'h0031);
    check("wrinc_mem31", mem_data, 8'h77);

    // Wrap and aliasing.
    load(16'h0100);
    write(8'h0F);
    load(16'hFFFF);
    check("ar_ffff", ar_out, 16'hFFFF);
    inc();
    check("wrap_ar", ar_out, 16'h0000);
    check("wrap_data", mem_data, 8'h0F);
    load(16'h0130);
    check("alias_130", mem_data, 8'hA5);

    // Contention suppresses write, sets err[0]; clear behaviour.
    load(16'h0040);
    write(8'h22);
    MEMbus = 1'b1; BUSmem = 1'b1; we = 1'b1; bus_in = 16'h0011;
    #1 check("cont_drive", mem_drive, 1'b0);
    tick();
    idle();
    check("cont_err", err, 3'b001);
    check("cont_data", mem_data, 8'h22);
    err_clr = 1'b1;
    tick();
    idle();
    check("clr_err", err, 3'b000);
    MEMbus = 1'b1; BUSmem = 1'b1; err_clr = 1'b1;
    tick();
    idle();
    check("clr_vs_new", err, 3'b001);
    err_clr = 1'b1;
    tick();
    idle();
    check("clr_err2", err, 3'b000);
    check("cont_mem40", mem_data, 8'h22);

    // AR conflict: load wins.
    ARload = 1'b1; ARinc = 1'b1; bus_in = 16'h0050;
    tick();
    idle();
    check("conf_ar", ar_out, 16'h0050);
    check("conf_err", err, 3'b010);
    err_clr = 1'b1;
    tick();
    idle();

    // Reset mid-write drops write and AR update.
    load(16'h0060);
    write(8'h44);
    ARload = 1'b1; ARinc = 1'b1; we = 1'b1; BUSmem = 1'b1; bus_in = 16'h0055;
    reset = 1'b0;
    tick();
    idle();
    check("rstw_ar", ar_out, 16'h0000);
    check("rstw_err", err, 3'b000);
    check("rstw_data", mem_data, 8'h00);
    reset = 1'b1;
    load(16'h0060);
    check("rstw_mem60", mem_data, 8'h44);

    // Write protection on low addresses (pre-seeded via alias 0x0105).
    load(16'h0105);
    write(8'h66);
    load(16'h0005);
    check("alias_05", mem_data, 8'h66);
    write(8'h77);
`ifdef MEM_WPROT_EN
    check("wprot_err", err, 3'b100);
    check("wprot_byp", mem_data, 8'h66);
`else
    check("wprot_err", err, 3'b000);
    check("wprot_byp", mem_data, 8'h77);
`endif
    load(16'h0006);
    load(16'h0005);
`ifdef MEM_WPROT_EN
    check("wprot_mem", mem_data, 8'h66);
`else
    check("wprot_mem", mem_data, 8'h77);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
